// File: rtl/defec_frame_pkg.sv
// rtl/defec_frame_pkg.sv - shared types and constants for the defec frame buffer
// Contents: write/read FSM state enums, length field width, header byte count.
package defec_frame_pkg;

  localparam int cLEN_W     = 16;  // width of the frame length field
  localparam int cHDR_BYTES = 2;   // length prefix bytes, HI byte first

  typedef enum logic [1:0] {
    W_HDR0,
    W_HDR1,
    W_DATA,
    W_DROP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/defec_sdp_ram.sv
// rtl/defec_sdp_ram.sv - simple dual-port RAM, one write port, registered read port
// Ports:
//   clk      clock
//   we/wa/wd write enable, address, data
//   re/ra    read enable, address
//   rd       read data, valid the cycle after re
module defec_sdp_ram #(
  parameter int pDW = 8,
  parameter int pAW = 11
) (
  input  logic           clk,
  input  logic           we,
  input  logic [pAW-1:0] wa,
  input  logic [pDW-1:0] wd,
  input  logic           re,
  input  logic [pAW-1:0] ra,
  output logic [pDW-1:0] rd
);

  logic [pDW-1:0] mem [2**pAW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/defec_frame_buffer.sv
// rtl/defec_frame_buffer.sv - store-and-forward buffer for length-prefixed frames
// Ports:
//   clk, rst (async, active low)
//   ival/idat/ierr   recovered byte stream and corruption flag (no backpressure)
//   irdy             downstream ready
//   oval/odat/osop/oeop  payload packet stream
//   odrop            one-cycle pulse per discarded frame
// Optional: DEFEC_FRAME_BUFFER_STAT_EN adds ofrm_cnt/odrop_cnt saturating counters.
module defec_frame_buffer
  import defec_frame_pkg::*;
#(
  parameter int pBUF_AW  = 11,
  parameter int pLEN_AW  = 3,
  parameter int pMAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ival,
  input  logic [7:0] idat,
  input  logic       ierr,
  input  logic       irdy,
  output logic       oval,
  output logic [7:0] odat,
  output logic       osop,
  output logic       oeop,
  output logic       odrop
`ifdef DEFEC_FRAME_BUFFER_STAT_EN
  ,
  output logic [15:0] ofrm_cnt,
  output logic [15:0] odrop_cnt
`endif
);

  localparam logic [pBUF_AW:0]   cBUF_DEPTH = {1'b1, {pBUF_AW{1'b0}}};
  localparam logic [pLEN_AW:0]   cLEN_DEPTH = {1'b1, {pLEN_AW{1'b0}}};
  localparam logic [pBUF_AW:0]   cB1 = 1;
  localparam logic [pBUF_AW-1:0] cF1 = 1;
  localparam logic [pLEN_AW:0]   cL1 = 1;

  // ---------------- write side ----------------
  wr_state_t             wstate, wstate_nxt;
  logic [cLEN_W-1:0]     len, wcnt, hdr_len;
  logic [pBUF_AW:0]      wr_ptr, wr_base, rd_ptr;
  logic [pLEN_AW:0]      lf_wr_ptr, lf_rd_ptr, fq_cnt;
  logic                  err, last, ram_full, lf_full;
  logic                  ram_we, commit, rollback, drop_now, delivered;

  always_comb begin
    hdr_len    = {len[7:0], idat};
    last       = (wcnt == len - 16'd1);
    ram_full   = ((wr_ptr - rd_ptr) == cBUF_DEPTH);
    // Frames count as queued until their last byte is handed over, so the
    // frame held by the reader still occupies a slot.
    lf_full    = (fq_cnt == cLEN_DEPTH);
    wstate_nxt = wstate;
    ram_we     = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    drop_now   = 1'b0;
    case (wstate)
      W_HDR0: if (ival) wstate_nxt = W_HDR1;
      W_HDR1: if (ival) begin
        if ((hdr_len == '0) || (hdr_len > cLEN_W'(pMAX_LEN))) begin
          drop_now   = 1'b1;
          wstate_nxt = W_HDR0;
        end else if (err || ierr) begin
          drop_now   = 1'b1;
          wstate_nxt = W_DROP;
        end else begin
          wstate_nxt = W_DATA;
        end
      end
      W_DATA: if (ival) begin
        if (err || ierr || ram_full || (last && lf_full)) begin
          rollback   = 1'b1;
          drop_now   = 1'b1;
          wstate_nxt = last ? W_HDR0 : W_DROP;
        end else begin
          ram_we = 1'b1;
          if (last) begin
            commit     = 1'b1;
            wstate_nxt = W_HDR0;
          end
        end
      end
      W_DROP: if (ival && last) wstate_nxt = W_HDR0;
      default: wstate_nxt = W_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wstate <= W_HDR0;
    else      wstate <= wstate_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len       <= '0;
      wcnt      <= '0;
      err       <= 1'b0;
      wr_ptr    <= '0;
      wr_base   <= '0;
      lf_wr_ptr <= '0;
      fq_cnt    <= '0;
      odrop     <= 1'b0;
    end else begin
      odrop <= drop_now;
      // Error is sticky from the HDR1 byte to the end of the frame; it is
      // acted on at the next byte, even if ierr has dropped by then.
      err <= ((wstate == W_HDR1) || (wstate == W_DATA)) ? (err | ierr) : 1'b0;
      if (ival) begin
        if (wstate == W_HDR0) len <= {8'h00, idat};
        if (wstate == W_HDR1) begin
          len  <= hdr_len;
          wcnt <= '0;
        end
        if ((wstate == W_DATA) || (wstate == W_DROP)) wcnt <= wcnt + 16'd1;
      end
      if (rollback)    wr_ptr <= wr_base;
      else if (ram_we) wr_ptr <= wr_ptr + cB1;
      if (commit) begin
        wr_base   <= wr_ptr + cB1;
        lf_wr_ptr <= lf_wr_ptr + cL1;
      end
      case ({commit, delivered})
        2'b10:   fq_cnt <= fq_cnt + cL1;
        2'b01:   fq_cnt <= fq_cnt - cL1;
        default: fq_cnt <= fq_cnt;
      endcase
    end
  end

  // ---------------- read side ----------------
  rd_state_t             rstate, rstate_nxt;
  logic [cLEN_W-1:0]     rem, rem_eff, lf_q;
  logic [pBUF_AW-1:0]    fptr;
  logic [7:0]            ram_q;
  logic                  first, inf_v, inf_sop, inf_eop, land_eop;
  logic                  pop, room, lf_empty, issue, lf_pop, iss_sop, iss_eop;
  logic [1:0]            scnt;
  logic [9:0]            e0, e1, land_word;  // {data, sop, eop}

  assign oval      = (scnt != 2'd0);
  assign odat      = e0[9:2];
  assign osop      = oval & e0[1];
  assign oeop      = oval & e0[0];
  assign pop       = oval & irdy;
  assign delivered = pop & e0[0];

  always_comb begin
    lf_empty = (lf_wr_ptr == lf_rd_ptr);
    // Fetch only when the skid pair can absorb the byte one cycle later,
    // counting the read already in flight and this cycle's handshake.
    room     = ({1'b0, scnt} + {2'b0, inf_v}) <= (3'd1 + {2'b0, pop});
    // The popped length is only readable in the first R_DATA cycle.
    rem_eff  = first ? (lf_q - 16'd1) : rem;
    land_eop = inf_sop ? (lf_q == 16'd1) : inf_eop;
    land_word = {ram_q, inf_sop, land_eop};
    rstate_nxt = rstate;
    issue      = 1'b0;
    lf_pop     = 1'b0;
    iss_sop    = 1'b0;
    iss_eop    = 1'b0;
    case (rstate)
      R_IDLE: if (!lf_empty && room) begin
        issue      = 1'b1;
        lf_pop     = 1'b1;
        iss_sop    = 1'b1;
        rstate_nxt = R_DATA;
      end
      R_DATA: begin
        if (rem_eff == '0) begin
          rstate_nxt = R_IDLE;
        end else if (room) begin
          issue   = 1'b1;
          iss_eop = (rem_eff == 16'd1);
          if (rem_eff == 16'd1) rstate_nxt = R_IDLE;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstate <= R_IDLE;
    else      rstate <= rstate_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem       <= '0;
      first     <= 1'b0;
      fptr      <= '0;
      rd_ptr    <= '0;
      lf_rd_ptr <= '0;
      inf_v     <= 1'b0;
      inf_sop   <= 1'b0;
      inf_eop   <= 1'b0;
      scnt      <= 2'd0;
      e0        <= '0;
      e1        <= '0;
    end else begin
      first   <= lf_pop;
      inf_v   <= issue;
      inf_sop <= iss_sop;
      inf_eop <= iss_eop;
      if (rstate == R_DATA) rem <= rem_eff - cLEN_W'(issue);
      if (issue)  fptr      <= fptr + cF1;
      if (lf_pop) lf_rd_ptr <= lf_rd_ptr + cL1;
      if (pop)    rd_ptr    <= rd_ptr + cB1;
      case ({pop, inf_v})
        2'b01: begin
          if (scnt == 2'd0) e0 <= land_word;
          else              e1 <= land_word;
          scnt <= scnt + 2'd1;
        end
        2'b10: begin
          e0   <= e1;
          scnt <= scnt - 2'd1;
        end
        2'b11: begin
          if (scnt == 2'd1) e0 <= land_word;
          else begin
            e0 <= e1;
            e1 <= land_word;
          end
        end
        default: scnt <= scnt;
      endcase
    end
  end

  defec_sdp_ram #(.pDW(8), .pAW(pBUF_AW)) u_payload_ram (
    .clk(clk), .we(ram_we), .wa(wr_ptr[pBUF_AW-1:0]), .wd(idat),
    .re(issue), .ra(fptr), .rd(ram_q)
  );

  defec_sdp_ram #(.pDW(cLEN_W), .pAW(pLEN_AW)) u_len_fifo_ram (
    .clk(clk), .we(commit), .wa(lf_wr_ptr[pLEN_AW-1:0]), .wd(len),
    .re(1'b1), .ra(lf_rd_ptr[pLEN_AW-1:0]), .rd(lf_q)
  );

`ifdef DEFEC_FRAME_BUFFER_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ofrm_cnt  <= '0;
      odrop_cnt <= '0;
    end else begin
      if (delivered && (ofrm_cnt != 16'hFFFF)) ofrm_cnt <= ofrm_cnt + 16'd1;
      if (odrop && (odrop_cnt != 16'hFFFF))    odrop_cnt <= odrop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_defec_frame_buffer.sv
// tb/tb_defec_frame_buffer.sv - self-checking bench for defec_frame_buffer
module tb_defec_frame_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ival = 1'b0;
  logic [7:0] idat = 8'h00;
  logic       ierr = 1'b0;
  logic       irdy = 1'b0;
  logic       oval, osop, oeop, odrop;
  logic [7:0] odat;

  int errors = 0;
  int checks = 0;
  int drops_seen = 0;
  int exp_drops = 0;
  logic [31:0] sb[$];
  bit   stall_prev = 1'b0;
  logic [9:0] prev_word = '0;

  defec_frame_buffer #(.pBUF_AW(4), .pLEN_AW(3), .pMAX_LEN(1518)) dut (
    .clk(clk), .rst(rst), .ival(ival), .idat(idat), .ierr(ierr), .irdy(irdy),
    .oval(oval), .odat(odat), .osop(osop), .oeop(oeop), .odrop(odrop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (odrop) drops_seen++;
      if (stall_prev)
        check("hold", 32'({oval, odat, osop, oeop}), 32'({1'b1, prev_word}));
      if (oval && irdy) begin
        exp_w = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check("byte", 32'({odat, osop, oeop}), exp_w);
      end
      stall_prev = oval && !irdy;
      prev_word  = {odat, osop, oeop};
    end
  end

  task automatic put(input logic [7:0] b, input logic e);
    ival = 1'b1;
    idat = b;
    ierr = e;
    @(posedge clk); #1;
    ival = 1'b0;
    ierr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input int len, input int base, input int step, input bit ok);
    logic [7:0] b;
    put(8'(len >> 8), 1'b0);
    put(8'(len), 1'b0);
    for (int i = 0; i < len; i++) begin
      b = 8'(base + i * step);
      put(b, 1'b0);
      if (ok) sb.push_back(32'({b, (i == 0), (i == len - 1)}));
    end
  endtask

  task automatic drain(input string tag, input bit rnd);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      if (rnd) irdy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    irdy = 1'b1;
    idle(6);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_drops(input string tag);
    idle(2);
    check(tag, 32'(drops_seen), 32'(exp_drops));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst = 1'b1;
    idle(1);
    check("rst_oval", 32'(oval), 32'd0);
    check("rst_odat", 32'(odat), 32'd0);
    check("rst_osop", 32'(osop), 32'd0);
    check("rst_oeop", 32'(oeop), 32'd0);
    check("rst_odrop", 32'(odrop), 32'd0);

    // basic frame and latency
    irdy = 1'b1;
    frame(3, 'h11, 'h11, 1'b1);
    @(negedge clk); check("lat_c1", 32'(oval), 32'd0);
    @(negedge clk); check("lat_c2", 32'(oval), 32'd0);
    @(negedge clk); check("lat_c3", 32'(oval), 32'd1);
    #1;
    drain("drain_basic", 1'b0);

    // zero length header, then a good frame
    put(8'h00, 1'b0); put(8'h00, 1'b0);
    exp_drops++;
    frame(2, 'hAA, 'h11, 1'b1);
    drain("drain_zero_len", 1'b0);
    check_drops("drops_zero_len");

    // over-length header (1519)
    put(8'h05, 1'b0); put(8'hEF, 1'b0);
    exp_drops++;
    check_drops("drops_max_len");

    // ierr mid-payload, then ierr in HDR0 ignored
    put(8'h00, 1'b0); put(8'h04, 1'b0);
    put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b1); put(8'h04, 1'b0);
    exp_drops++;
    put(8'h00, 1'b1); put(8'h01, 1'b0); put(8'h55, 1'b0);
    sb.push_back(32'({8'h55, 1'b1, 1'b1}));
    drain("drain_ierr", 1'b0);
    check_drops("drops_ierr");

    // RAM full: second 10-byte frame does not fit 16 bytes
    irdy = 1'b0;
    frame(10, 'h20, 1, 1'b1);
    frame(10, 'h40, 1, 1'b0);
    exp_drops++;
    check_drops("drops_ram_full");
    check("stall_oval", 32'(oval), 32'd1);
    check("stall_odat", 32'(odat), 32'h20);
    irdy = 1'b1;
    drain("drain_ram_full", 1'b0);
    frame(16, 'h80, 3, 1'b1);
    drain("drain_wrap16", 1'b0);
    check_drops("drops_wrap16");

    // length FIFO full: ninth queued frame dropped
    irdy = 1'b0;
    for (int k = 0; k < 9; k++) frame(1, 'h60 + k, 1, (k < 8));
    exp_drops++;
    check_drops("drops_len_full");
    drain("drain_len_full", 1'b1);

    // async reset mid-output and mid-payload
    irdy = 1'b0;
    frame(2, 'hA1, 1, 1'b1);
    put(8'h00, 1'b0); put(8'h05, 1'b0); put(8'hB1, 1'b0); put(8'hB2, 1'b0);
    check("pre_rst_oval", 32'(oval), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_oval", 32'(oval), 32'd0);
    check("mid_rst_odat", 32'(odat), 32'd0);
    check("mid_rst_osop", 32'(osop), 32'd0);
    check("mid_rst_oeop", 32'(oeop), 32'd0);
    check("mid_rst_odrop", 32'(odrop), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    irdy = 1'b1;
    frame(1, 'h7E, 1, 1'b1);
    drain("drain_post_rst", 1'b0);
    check_drops("drops_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
